// File: rtl/relu_grad_mask_if.sv
// Handshake bundle between relu_grad_mask and its forward/backward neighbours.
// The DUT takes the slave modport; the master modport drives the streams.
interface relu_grad_mask_if #(
    parameter int WIDTH      = 8,
    parameter int GRAD_WIDTH = 16
);
    logic                         fwd_valid;
    logic signed [WIDTH-1:0]      fwd_data;
    logic                         fwd_ready;
    logic                         bwd_in_valid;
    logic signed [GRAD_WIDTH-1:0] bwd_in_grad;
    logic                         bwd_in_ready;
    logic                         bwd_out_valid;
    logic signed [GRAD_WIDTH-1:0] bwd_out_grad;
    logic                         bwd_out_ready;
    logic                         mask_full;
    logic                         apply_done;

    modport master (
        output fwd_valid, fwd_data, bwd_in_valid, bwd_in_grad, bwd_out_ready,
        input  fwd_ready, bwd_in_ready, bwd_out_valid, bwd_out_grad, mask_full, apply_done
    );

    modport slave (
        input  fwd_valid, fwd_data, bwd_in_valid, bwd_in_grad, bwd_out_ready,
        output fwd_ready, bwd_in_ready, bwd_out_valid, bwd_out_grad, mask_full, apply_done
    );
endinterface

// File: rtl/relu_grad_mask.sv
// ReLU backward-pass mask: records sign of each forward pre-activation, then
// zeroes returning gradients wherever the forward ReLU clamped its input.
module relu_grad_mask #(
    parameter int WIDTH      = 8,
    parameter int GRAD_WIDTH = 16,
    parameter int DEPTH      = 784
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    relu_grad_mask_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {CAPTURE = 1'b0, APPLY = 1'b1} state_t;

    // Zero passes through the forward ReLU, so it keeps its gradient.
    function automatic logic relu_pass(input logic signed [WIDTH-1:0] x);
        return (x >= 0);
    endfunction

    function automatic logic signed [GRAD_WIDTH-1:0] mask_grad(
        input logic                         keep,
        input logic signed [GRAD_WIDTH-1:0] g
    );
        return keep ? g : '0;
    endfunction

    state_t                       r_state;
    logic [DEPTH-1:0]             r_mask;
    logic [IDX_W-1:0]             r_wr_idx;
    logic [IDX_W-1:0]             r_rd_idx;
    logic signed [GRAD_WIDTH-1:0] r_grad_p1;
    logic                         r_vld_p1;
    logic                         r_done;

    logic          w_fwd_acc;
    logic          w_bwd_rdy;
    logic          w_bwd_acc;
    logic [AW-1:0] w_wr_sel;
    logic [AW-1:0] w_rd_sel;

    assign w_fwd_acc = bus.fwd_valid && (r_state == CAPTURE);
    assign w_bwd_rdy = (r_state == APPLY) && (!r_vld_p1 || bus.bwd_out_ready);
    assign w_bwd_acc = bus.bwd_in_valid && w_bwd_rdy;
    assign w_wr_sel  = r_wr_idx[AW-1:0];
    assign w_rd_sel  = r_rd_idx[AW-1:0];

    // Mask storage is never cleared; every bit is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_fwd_acc)
            r_mask[w_wr_sel] <= relu_pass(bus.fwd_data);
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state   <= CAPTURE;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_grad_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CAPTURE: begin
                    if (w_fwd_acc) begin
                        if (r_wr_idx == LAST) begin
                            r_wr_idx <= '0;
                            r_state  <= APPLY;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                APPLY: begin
                    if (w_bwd_acc) begin
                        if (r_rd_idx == LAST) begin
                            r_rd_idx <= '0;
                            r_state  <= CAPTURE;
                            r_done   <= 1'b1;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= CAPTURE;
            endcase

            // ---- stage p1: masked gradient output register ----
            // Drains on its own, so it may still hold the last gradient in CAPTURE.
            if (w_bwd_acc) begin
                r_grad_p1 <= mask_grad(r_mask[w_rd_sel], bus.bwd_in_grad);
                r_vld_p1  <= 1'b1;
            end else if (r_vld_p1 && bus.bwd_out_ready) begin
                r_vld_p1  <= 1'b0;
            end
        end
    end

    assign bus.fwd_ready     = (r_state == CAPTURE);
    assign bus.bwd_in_ready  = w_bwd_rdy;
    assign bus.bwd_out_valid = r_vld_p1;
    assign bus.bwd_out_grad  = r_grad_p1;
    assign bus.mask_full     = (r_state == APPLY);
    assign bus.apply_done    = r_done;
endmodule

// File: tb/tb_relu_grad_mask.sv
// Directed bench for relu_grad_mask with a 4-element frame: reset, masking,
// backpressure, handshake gating, flush and randomised back-to-back frames.
module tb_relu_grad_mask;
    localparam int WIDTH      = 8;
    localparam int GRAD_WIDTH = 16;
    localparam int DEPTH      = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    relu_grad_mask_if #(.WIDTH(WIDTH), .GRAD_WIDTH(GRAD_WIDTH)) bus ();

    relu_grad_mask #(.WIDTH(WIDTH), .GRAD_WIDTH(GRAD_WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_done = 0;

    logic signed [GRAD_WIDTH-1:0] out_q[$];
    logic signed [GRAD_WIDTH-1:0] exp_q[$];

    // Every transfer on the output side and every apply_done pulse is logged.
    always @(negedge clk) begin
        if (bus.bwd_out_valid && bus.bwd_out_ready) out_q.push_back(bus.bwd_out_grad);
        if (bus.apply_done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_elem%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fwd(input logic signed [WIDTH-1:0] v[DEPTH]);
        for (int i = 0; i < DEPTH; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_data  = v[i];
            tick();
        end
        bus.fwd_valid = 1'b0;
    endtask

    task automatic send_bwd(input logic signed [GRAD_WIDTH-1:0] g[DEPTH]);
        bus.bwd_out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.bwd_in_valid = 1'b1;
            bus.bwd_in_grad  = g[i];
            tick();
        end
        bus.bwd_in_valid = 1'b0;
    endtask

    logic signed [WIDTH-1:0]      fv[DEPTH];
    logic signed [GRAD_WIDTH-1:0] gv[DEPTH];
    logic signed [GRAD_WIDTH-1:0] ev[DEPTH];

    initial begin
        int idx;
        int budget;
        int done0;
        logic acc;

        rst = 1'b1;
        flush = 1'b0;
        bus.fwd_valid = 1'b0;
        bus.fwd_data = '0;
        bus.bwd_in_valid = 1'b0;
        bus.bwd_in_grad = '0;
        bus.bwd_out_ready = 1'b1;
        tick();
        tick();
        check("rst_fwd_ready",  bus.fwd_ready, 1);
        check("rst_in_ready",   bus.bwd_in_ready, 0);
        check("rst_out_valid",  bus.bwd_out_valid, 0);
        check("rst_out_grad",   bus.bwd_out_grad, 0);
        check("rst_mask_full",  bus.mask_full, 0);
        check("rst_apply_done", bus.apply_done, 0);
        rst = 1'b0;

        // Frame 1: basic masking, gradients offered during CAPTURE must be ignored.
        fv = '{-8'sd3, 8'sd0, 8'sd5, -8'sd128};
        gv = '{16'sd100, 16'sd200, -16'sd300, 16'sd400};
        ev = '{16'sd0, 16'sd200, -16'sd300, 16'sd0};
        out_q.delete();
        bus.bwd_in_valid = 1'b1;
        bus.bwd_in_grad  = 16'sd999;
        for (int i = 0; i < DEPTH; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_data  = fv[i];
            #1;
            check("f1_fwd_ready", bus.fwd_ready, 1);
            check("f1_cap_in_ready", bus.bwd_in_ready, 0);
            check("f1_cap_mask_full", bus.mask_full, 0);
            tick();
        end
        bus.fwd_valid = 1'b0;
        bus.bwd_in_valid = 1'b0;
        check("f1_mask_full", bus.mask_full, 1);
        check("f1_apply_fwd_ready", bus.fwd_ready, 0);
        check("f1_no_cap_output", bus.bwd_out_valid, 0);
        for (int i = 0; i < DEPTH; i++) begin
            bus.bwd_in_valid = 1'b1;
            bus.bwd_in_grad  = gv[i];
            #1;
            check("f1_in_ready", bus.bwd_in_ready, 1);
            tick();
            check("f1_out_valid", bus.bwd_out_valid, 1);
            check($sformatf("f1_out_grad%0d", i), bus.bwd_out_grad, ev[i]);
            check("f1_apply_done", bus.apply_done, (i == DEPTH - 1));
            check("f1_turn_fwd_ready", bus.fwd_ready, (i == DEPTH - 1));
        end
        bus.bwd_in_valid = 1'b0;
        #1;
        check("f1_post_in_ready", bus.bwd_in_ready, 0);
        tick();
        check("f1_post_out_valid", bus.bwd_out_valid, 0);
        check("f1_post_apply_done", bus.apply_done, 0);
        exp_q = '{ev[0], ev[1], ev[2], ev[3]};
        check_q("f1_q");

        // Frame 2: boundary values, backpressure, fwd_valid held during APPLY.
        fv = '{8'sd127, -8'sd1, 8'sd1, -8'sd50};
        gv = '{-16'sd32768, 16'sd12345, 16'sd7, -16'sd1};
        ev = '{-16'sd32768, 16'sd0, 16'sd7, 16'sd0};
        out_q.delete();
        send_fwd(fv);
        bus.fwd_valid = 1'b1;
        bus.fwd_data  = -8'sd5;
        bus.bwd_in_valid = 1'b1;
        bus.bwd_in_grad  = gv[0];
        #1;
        check("f2_apply_fwd_ready", bus.fwd_ready, 0);
        tick();
        bus.bwd_out_ready = 1'b0;
        bus.bwd_in_grad   = gv[1];
        for (int k = 0; k < 3; k++) begin
            #1;
            check("f2_bp_in_ready", bus.bwd_in_ready, 0);
            check("f2_bp_out_valid", bus.bwd_out_valid, 1);
            check("f2_bp_out_grad", bus.bwd_out_grad, ev[0]);
            check("f2_bp_fwd_ready", bus.fwd_ready, 0);
            tick();
        end
        bus.bwd_out_ready = 1'b1;
        #1;
        check("f2_release_in_ready", bus.bwd_in_ready, 1);
        tick();
        bus.bwd_in_grad = gv[2];
        tick();
        bus.bwd_in_grad = gv[3];
        tick();
        bus.fwd_valid = 1'b0;
        bus.bwd_in_valid = 1'b0;
        tick();
        exp_q = '{ev[0], ev[1], ev[2], ev[3]};
        check_q("f2_q");

        // Frame 3: flush after two accepts with the second output still pending.
        fv = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        out_q.delete();
        send_fwd(fv);
        bus.bwd_in_valid = 1'b1;
        bus.bwd_in_grad  = 16'sd10;
        tick();
        bus.bwd_in_grad  = 16'sd20;
        tick();
        bus.bwd_out_ready = 1'b0;
        bus.bwd_in_grad   = 16'sd30;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.bwd_in_valid = 1'b0;
        check("fl_out_valid", bus.bwd_out_valid, 0);
        check("fl_fwd_ready", bus.fwd_ready, 1);
        check("fl_mask_full", bus.mask_full, 0);
        check("fl_apply_done", bus.apply_done, 0);
        check("fl_out_grad", bus.bwd_out_grad, 0);
        exp_q = '{16'sd10};
        check_q("fl_partial_q");
        bus.bwd_out_ready = 1'b1;
        out_q.delete();
        fv = '{-8'sd1, 8'sd5, -8'sd7, 8'sd9};
        gv = '{16'sd11, 16'sd22, 16'sd33, 16'sd44};
        send_fwd(fv);
        send_bwd(gv);
        tick();
        exp_q = '{16'sd0, 16'sd22, 16'sd0, 16'sd44};
        check_q("fl_fresh_q");

        // Three back-to-back random frames against a mask = (x >= 0) model.
        out_q.delete();
        exp_q.delete();
        done0 = n_done;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                fv[i] = WIDTH'($urandom);
                gv[i] = GRAD_WIDTH'($urandom);
                exp_q.push_back((fv[i] >= 0) ? gv[i] : '0);
            end
            idx = 0;
            budget = 200;
            while (idx < DEPTH && budget > 0) begin
                bus.fwd_valid     = ($urandom_range(0, 2) != 0);
                bus.fwd_data      = fv[idx];
                bus.bwd_out_ready = $urandom_range(0, 1);
                #1;
                acc = bus.fwd_valid && bus.fwd_ready;
                tick();
                if (acc) idx++;
                budget--;
            end
            bus.fwd_valid = 1'b0;
            check($sformatf("rnd%0d_fwd_count", f), idx, DEPTH);
            idx = 0;
            budget = 200;
            while (idx < DEPTH && budget > 0) begin
                bus.bwd_in_valid  = ($urandom_range(0, 2) != 0);
                bus.bwd_in_grad   = gv[idx];
                bus.bwd_out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = bus.bwd_in_valid && bus.bwd_in_ready;
                tick();
                if (acc) idx++;
                budget--;
            end
            bus.bwd_in_valid = 1'b0;
            check($sformatf("rnd%0d_bwd_count", f), idx, DEPTH);
        end
        bus.bwd_out_ready = 1'b1;
        budget = 20;
        while (bus.bwd_out_valid && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        check("rnd_drained", bus.bwd_out_valid, 0);
        check("rnd_apply_done_count", n_done - done0, 3);
        check_q("rnd_q");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/relu_grad_mask.md
# relu_grad_mask

Backward-pass companion to the forward ReLU activation in the CNN datapath. During the forward pass it records one mask bit per activation: 1 if the pre-activation was non-negative (sign bit clear), 0 otherwise. During the backward pass it streams incoming gradients through that mask in the same element order, zeroing gradients where the forward ReLU clamped its input. It sits between a conv/pool layer's forward output stream and the matching gradient stream coming back from the next layer.

## Interface
- WIDTH, 8: bit width of forward pre-activation data (signed).
- GRAD_WIDTH, 16: bit width of gradient data (signed).
- DEPTH, 784: activations per frame (mask bits stored).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous abort. Returns to CAPTURE and clears counters and output register.
- fwd_valid  in  1  forward pre-activation valid.
- fwd_data  in  WIDTH  signed pre-activation (the forward ReLU's input).
- fwd_ready  out  1  high in CAPTURE state.
- bwd_in_valid  in  1  upstream gradient valid.
- bwd_in_grad  in  GRAD_WIDTH  signed upstream gradient.
- bwd_in_ready  out  1  gradient accept.
- bwd_out_valid  out  1  masked gradient valid.
- bwd_out_grad  out  GRAD_WIDTH  masked gradient.
- bwd_out_ready  in  1  downstream accept.
- mask_full  out  1  high in APPLY state (full frame of mask captured).
- apply_done  out  1  one-cycle pulse after the last gradient of a frame is accepted.

## Operation
- Storage: DEPTH-bit mask register array. Write pointer wr_idx and read pointer rd_idx, each $clog2(DEPTH+1) bits.
- States: CAPTURE, APPLY.
- CAPTURE:
  - fwd_ready=1 and bwd_in_ready=0.
  - On fwd_valid&fwd_ready: mask[wr_idx] = ~fwd_data[WIDTH-1], then wr_idx++.
  - Zero input gives mask bit 1, matching the forward ReLU, which passes zero through.
  - The accept with wr_idx==DEPTH-1 moves the block to APPLY with wr_idx=0.
- APPLY:
  - fwd_ready=0.
  - bwd_in_ready = !bwd_out_valid || bwd_out_ready (single output register, full throughput).
  - On accept: the output register loads mask[rd_idx] ? bwd_in_grad : 0, then rd_idx++.
  - The accept with rd_idx==DEPTH-1 moves the block to CAPTURE with rd_idx=0, and pulses apply_done in the next cycle.
- After the last gradient, the output register drains independently. A new forward frame may be captured while the final gradient is still held.
- bwd_out_valid clears on bwd_out_valid&bwd_out_ready with no new accept. On a simultaneous consume and accept, the register reloads and valid stays 1.
- The gradient passes bit-exact with no width change. Masked elements are all-zeros.
- Element order is identical in both passes: first forward element pairs with first gradient.
- Priority: rst > flush > handshakes. An input handshake in a flush cycle is discarded.
- Mask contents need not be cleared by rst or flush; stale bits are overwritten before being read.

## Timing
- Reset values:
  - state=CAPTURE, so fwd_ready=1 in the first cycle after reset.
  - bwd_in_ready=0, bwd_out_valid=0, bwd_out_grad=0.
  - mask_full=0, apply_done=0, wr_idx=rd_idx=0.
- Forward capture: 1 element per cycle. Sustained fwd_valid fills the mask in exactly DEPTH cycles. mask_full rises the cycle after the DEPTH-th accept.
- Backward latency: gradient accepted at edge t appears on bwd_out_* from t+1.
- Backward throughput: 1 per cycle while bwd_out_ready=1.
- Backpressure: bwd_out_ready=0 with bwd_out_valid=1 holds bwd_out_grad stable and forces bwd_in_ready=0.
- bwd_out_grad holds its last value when bwd_out_valid=0.
- Frame turnaround:
  - After the last backward accept, fwd_ready=1 on the next cycle. apply_done=1 on that same cycle for exactly one cycle.
  - bwd_in_ready=0 from the cycle after the last accept.
- flush or rst mid-frame: on the next cycle state=CAPTURE, both counters=0, bwd_out_valid=0, apply_done=0, and no partial-frame output.

## Test plan
- DEPTH=4, forward -3,0,5,-128, then gradients 100,200,-300,400 with bwd_out_ready=1.
  - Required: outputs 0,200,-300,0 on consecutive cycles, each 1 cycle after its accept.
  - Required: apply_done pulses once; fwd_ready returns high.
- Backpressure: hold bwd_out_ready=0 for 3 cycles mid-frame.
  - Required: bwd_in_ready=0 and bwd_out_grad stable throughout.
  - Required: no gradient lost or duplicated; output count=DEPTH.
- Boundary values:
  - Forward +127 and -1: mask 1 and 0.
  - Gradient -32768 through mask 1 emerges unchanged.
  - Gradient through mask 0 emerges as 0.
- Handshake gating:
  - Gradients presented during CAPTURE are never accepted (bwd_in_ready=0).
  - fwd_valid during APPLY is never accepted (fwd_ready=0).
- Flush after 2 of 4 backward accepts, with one output pending.
  - Required: next cycle bwd_out_valid=0 and fwd_ready=1.
  - Required: a fresh frame is masked correctly from element 0.
- Back-to-back frames with random valid/ready gaps, checked against a reference model of mask=(x>=0). Required: bit-exact, 3 frames.
